// File: rtl/pc_ctrl.sv
// pc_ctrl: front-end sequencing controller for the PC register.
// It picks one redirect source (trap > EX > ID) and drives the PC
// register's jump_en/jump_addr inputs. To stall, it jumps to the current PC.
// It defers a redirect while the instruction bus is busy and generates the
// IF/ID and ID/EX flush/stall controls. It also counts applied redirects.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   pc_i                current PC register output
//   trap_req_i/addr_i   trap request (level, held until trap_ack_o) and vector
//   ex_jump_en_i/addr_i EX-stage branch/JALR redirect
//   id_jump_en_i/addr_i ID-stage JAL redirect
//   load_use_stall_i    load-use hazard from decode
//   ifetch_busy_i       instruction bus cannot accept a new address
//   jump_en_o/addr_o    to PC register
//   flush_ifid_o        invalidate IF/ID on next edge
//   flush_idex_o        bubble into ID/EX on next edge
//   stall_ifid_o        hold IF/ID
//   trap_ack_o          one-cycle pulse when the trap vector is applied
//   redirect_cnt_o      applied-redirect counter (wraps)
module pc_ctrl #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic                  trap_req_i,
    input  logic [ADDR_WIDTH-1:0] trap_addr_i,
    input  logic                  ex_jump_en_i,
    input  logic [ADDR_WIDTH-1:0] ex_jump_addr_i,
    input  logic                  id_jump_en_i,
    input  logic [ADDR_WIDTH-1:0] id_jump_addr_i,
    input  logic                  load_use_stall_i,
    input  logic                  ifetch_busy_i,
    output logic                  jump_en_o,
    output logic [ADDR_WIDTH-1:0] jump_addr_o,
    output logic                  flush_ifid_o,
    output logic                  flush_idex_o,
    output logic                  stall_ifid_o,
    output logic                  trap_ack_o,
    output logic [CNT_WIDTH-1:0]  redirect_cnt_o
);

    typedef enum logic {ST_RUN, ST_PEND} state_t;
    // A larger encoding means a higher priority, so a plain compare can rank requests.
    typedef enum logic [1:0] {SRC_ID = 2'd0, SRC_EX = 2'd1, SRC_TRAP = 2'd2} src_t;

    state_t                state_q, state_d;
    src_t                  pend_src_q, pend_src_d;
    logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  cnt_inc;

    logic                  win_vld;
    src_t                  win_src;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic                  win_higher;
    src_t                  app_src;

    // Priority select among the redirect sources.
    always_comb begin
        win_vld  = 1'b1;
        win_src  = SRC_ID;
        win_addr = id_jump_addr_i;
        if (trap_req_i) begin
            win_src  = SRC_TRAP;
            win_addr = trap_addr_i;
        end else if (ex_jump_en_i) begin
            win_src  = SRC_EX;
            win_addr = ex_jump_addr_i;
        end else if (!id_jump_en_i) begin
            win_vld  = 1'b0;
        end
    end

    assign win_higher = win_vld && (win_src > pend_src_q);

    always_comb begin
        state_d      = state_q;
        pend_src_d   = pend_src_q;
        pend_addr_d  = pend_addr_q;
        cnt_inc      = 1'b0;
        app_src      = pend_src_q;
        jump_en_o    = 1'b0;
        jump_addr_o  = '0;
        flush_ifid_o = 1'b0;
        flush_idex_o = 1'b0;
        stall_ifid_o = 1'b0;
        trap_ack_o   = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (win_vld) begin
                    jump_en_o    = 1'b1;
                    flush_ifid_o = 1'b1;
                    flush_idex_o = (win_src != SRC_ID);
                    if (!ifetch_busy_i) begin
                        jump_addr_o = win_addr;
                        trap_ack_o  = (win_src == SRC_TRAP);
                        cnt_inc     = 1'b1;
                    end else begin
                        jump_addr_o = pc_i;
                        pend_addr_d = win_addr;
                        pend_src_d  = win_src;
                        state_d     = ST_PEND;
                    end
                end else if (ifetch_busy_i || load_use_stall_i) begin
                    jump_en_o    = 1'b1;
                    jump_addr_o  = pc_i;
                    stall_ifid_o = 1'b1;
                    flush_idex_o = load_use_stall_i;
                end
            end
            ST_PEND: begin
                jump_en_o    = 1'b1;
                flush_ifid_o = 1'b1;
                flush_idex_o = 1'b1;
                if (ifetch_busy_i) begin
                    jump_addr_o = pc_i;
                    if (win_higher) begin
                        pend_addr_d = win_addr;
                        pend_src_d  = win_src;
                    end
                end else begin
                    jump_addr_o = win_higher ? win_addr : pend_addr_q;
                    app_src     = win_higher ? win_src : pend_src_q;
                    trap_ack_o  = (app_src == SRC_TRAP);
                    cnt_inc     = 1'b1;
                    state_d     = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            pend_src_q  <= SRC_ID;
            pend_addr_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pend_src_q  <= pend_src_d;
            pend_addr_q <= pend_addr_d;
            if (cnt_inc) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign redirect_cnt_o = cnt_q;

endmodule

// File: tb/tb_pc_ctrl.sv
module tb_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_i = '0;
    logic        trap_req_i = 1'b0;
    logic [31:0] trap_addr_i = '0;
    logic        ex_jump_en_i = 1'b0;
    logic [31:0] ex_jump_addr_i = '0;
    logic        id_jump_en_i = 1'b0;
    logic [31:0] id_jump_addr_i = '0;
    logic        load_use_stall_i = 1'b0;
    logic        ifetch_busy_i = 1'b0;
    logic        jump_en_o;
    logic [31:0] jump_addr_o;
    logic        flush_ifid_o, flush_idex_o, stall_ifid_o, trap_ack_o;
    logic [3:0]  redirect_cnt_o;

    int errors = 0;
    int checks = 0;
    logic [3:0] exp_cnt;

    pc_ctrl #(.ADDR_WIDTH(32), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .pc_i(pc_i),
        .trap_req_i(trap_req_i), .trap_addr_i(trap_addr_i),
        .ex_jump_en_i(ex_jump_en_i), .ex_jump_addr_i(ex_jump_addr_i),
        .id_jump_en_i(id_jump_en_i), .id_jump_addr_i(id_jump_addr_i),
        .load_use_stall_i(load_use_stall_i), .ifetch_busy_i(ifetch_busy_i),
        .jump_en_o(jump_en_o), .jump_addr_o(jump_addr_o),
        .flush_ifid_o(flush_ifid_o), .flush_idex_o(flush_idex_o),
        .stall_ifid_o(stall_ifid_o), .trap_ack_o(trap_ack_o),
        .redirect_cnt_o(redirect_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        trap; logic [31:0] taddr;
        logic        ex;   logic [31:0] eaddr;
        logic        id;   logic [31:0] iaddr;
        logic        lus;  logic        busy;
        logic        je;   logic [31:0] ja;
        logic        fi;   logic        fx;
        logic        st;   logic        ack;
        logic [3:0]  cnt;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic trap, input logic [31:0] taddr,
                         input logic ex, input logic [31:0] eaddr,
                         input logic id, input logic [31:0] iaddr,
                         input logic lus, input logic busy);
        pc_i = pc; trap_req_i = trap; trap_addr_i = taddr;
        ex_jump_en_i = ex; ex_jump_addr_i = eaddr;
        id_jump_en_i = id; id_jump_addr_i = iaddr;
        load_use_stall_i = lus; ifetch_busy_i = busy;
    endtask

    task automatic chk_out(input string name, input logic je, input logic [31:0] ja,
                           input logic fi, input logic fx, input logic st, input logic ack);
        chk({name, ".jump_en"},    32'(jump_en_o),    32'(je));
        chk({name, ".jump_addr"},  jump_addr_o,       ja);
        chk({name, ".flush_ifid"}, 32'(flush_ifid_o), 32'(fi));
        chk({name, ".flush_idex"}, 32'(flush_idex_o), 32'(fx));
        chk({name, ".stall_ifid"}, 32'(stall_ifid_o), 32'(st));
        chk({name, ".trap_ack"},   32'(trap_ack_o),   32'(ack));
    endtask

    // Outputs are sampled mid-cycle, then the edge is taken and the counter is checked.
    task automatic cycle_end(input string name);
        @(posedge clk); #1;
        chk({name, ".cnt"}, 32'(redirect_cnt_o), 32'(exp_cnt));
    endtask

    initial begin
        //          pc     trap taddr  ex eaddr   id iaddr   lus busy je ja     fi fx st ack cnt
        vecs[0]  = '{32'h0,  0, 0,     0, 0,      0, 0,      0,  0,   0, 0,     0, 0, 0, 0, 0};
        vecs[1]  = '{32'h4,  0, 0,     0, 0,      0, 0,      0,  0,   0, 0,     0, 0, 0, 0, 0};
        vecs[2]  = '{32'h8,  0, 0,     0, 0,      0, 0,      0,  0,   0, 0,     0, 0, 0, 0, 0};
        vecs[3]  = '{32'h20, 0, 0,     1, 32'h100, 1, 32'h200, 0, 0,   1, 32'h100, 1, 1, 0, 0, 1};
        vecs[4]  = '{32'h40, 0, 0,     0, 0,      0, 0,      1,  0,   1, 32'h40, 0, 1, 1, 0, 1};
        vecs[5]  = '{32'h40, 0, 0,     0, 0,      0, 0,      1,  0,   1, 32'h40, 0, 1, 1, 0, 1};
        vecs[6]  = '{32'h44, 0, 0,     0, 0,      0, 0,      0,  1,   1, 32'h44, 0, 0, 1, 0, 1};
        vecs[7]  = '{32'h48, 0, 0,     0, 0,      1, 32'h300, 0, 0,   1, 32'h300, 1, 0, 0, 0, 2};
        vecs[8]  = '{32'h50, 1, 32'h80, 1, 32'h500, 1, 32'h600, 0, 0, 1, 32'h80, 1, 1, 0, 1, 3};
        vecs[9]  = '{32'h84, 0, 0,     0, 0,      1, 32'h700, 1, 0,   1, 32'h700, 1, 0, 0, 0, 4};
        vecs[10] = '{32'h88, 0, 0,     1, 32'h900, 0, 0,     1,  0,   1, 32'h900, 1, 1, 0, 0, 5};
        vecs[11] = '{32'h90, 0, 0,     0, 0,      0, 0,      0,  0,   0, 0,     0, 0, 0, 0, 5};

        // Reset state with idle inputs.
        #1;
        chk_out("reset", 0, 0, 0, 0, 0, 0);
        chk("reset.cnt", 32'(redirect_cnt_o), 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].pc, vecs[i].trap, vecs[i].taddr, vecs[i].ex, vecs[i].eaddr,
                  vecs[i].id, vecs[i].iaddr, vecs[i].lus, vecs[i].busy);
            @(negedge clk);
            chk_out($sformatf("vec%0d", i), vecs[i].je, vecs[i].ja, vecs[i].fi,
                    vecs[i].fx, vecs[i].st, vecs[i].ack);
            @(posedge clk); #1;
            chk($sformatf("vec%0d.cnt", i), 32'(redirect_cnt_o), 32'(vecs[i].cnt));
        end
        exp_cnt = 4'd5;

        // ID jump deferred by busy; EX overrides in the 2nd busy cycle.
        drive(32'hA0, 0, 0, 0, 0, 1, 32'h300, 0, 1);
        @(negedge clk); chk_out("seqA.c1", 1, 32'hA0, 1, 0, 0, 0); cycle_end("seqA.c1");
        drive(32'hA0, 0, 0, 1, 32'h500, 0, 0, 1, 1);
        @(negedge clk); chk_out("seqA.c2", 1, 32'hA0, 1, 1, 0, 0); cycle_end("seqA.c2");
        drive(32'hA0, 0, 0, 0, 0, 0, 0, 1, 1);
        @(negedge clk); chk_out("seqA.c3", 1, 32'hA0, 1, 1, 0, 0); cycle_end("seqA.c3");
        drive(32'hA0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); chk_out("seqA.rel", 1, 32'h500, 1, 1, 0, 0);
        exp_cnt++; cycle_end("seqA.rel");
        drive(32'h500, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); chk_out("seqA.idle", 0, 0, 0, 0, 0, 0); cycle_end("seqA.idle");

        // Equal and lower priority requests do not displace a pending EX.
        drive(32'hB0, 0, 0, 1, 32'h510, 0, 0, 0, 1);
        @(negedge clk); chk_out("seqD.c1", 1, 32'hB0, 1, 1, 0, 0); cycle_end("seqD.c1");
        drive(32'hB0, 0, 0, 1, 32'h520, 0, 0, 0, 1);
        @(negedge clk); chk_out("seqD.c2", 1, 32'hB0, 1, 1, 0, 0); cycle_end("seqD.c2");
        drive(32'hB0, 0, 0, 0, 0, 1, 32'h530, 0, 0);
        @(negedge clk); chk_out("seqD.rel", 1, 32'h510, 1, 1, 0, 0);
        exp_cnt++; cycle_end("seqD.rel");

        // Trap arrives while EX is pending; acked only on release.
        drive(32'hC0, 0, 0, 1, 32'h500, 0, 0, 0, 1);
        @(negedge clk); chk_out("seqB.c1", 1, 32'hC0, 1, 1, 0, 0); cycle_end("seqB.c1");
        drive(32'hC0, 1, 32'h80, 0, 0, 0, 0, 0, 1);
        @(negedge clk); chk_out("seqB.c2", 1, 32'hC0, 1, 1, 0, 0); cycle_end("seqB.c2");
        drive(32'hC0, 1, 32'h80, 0, 0, 0, 0, 0, 0);
        @(negedge clk); chk_out("seqB.rel", 1, 32'h80, 1, 1, 0, 1);
        exp_cnt++; cycle_end("seqB.rel");
        drive(32'h80, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); chk_out("seqB.idle", 0, 0, 0, 0, 0, 0); cycle_end("seqB.idle");

        // Counter wraps modulo 16.
        for (int i = 0; i < 16; i++) begin
            drive(32'hD0, 0, 0, 0, 0, 1, 32'h1000 + 32'(i), 0, 0);
            @(negedge clk);
            chk($sformatf("wrap%0d.ja", i), jump_addr_o, 32'h1000 + 32'(i));
            exp_cnt++; cycle_end($sformatf("wrap%0d", i));
        end

        // Reset while pending discards the redirect.
        drive(32'hE0, 1, 32'h80, 0, 0, 0, 0, 0, 1);
        @(negedge clk); chk_out("seqC.c1", 1, 32'hE0, 1, 1, 0, 0); cycle_end("seqC.c1");
        drive(32'hE0, 0, 0, 0, 0, 0, 0, 0, 1);
        #2 rst_n = 1'b0;
        #1 chk_out("seqC.rst_busy", 1, 32'hE0, 0, 0, 1, 0);
        drive(32'hE0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk_out("seqC.rst_idle", 0, 0, 0, 0, 0, 0);
        chk("seqC.rst_cnt", 32'(redirect_cnt_o), 0);
        @(negedge clk); rst_n = 1'b1;
        exp_cnt = '0;
        @(posedge clk); #1;
        @(negedge clk); chk_out("seqC.after", 0, 0, 0, 0, 0, 0); cycle_end("seqC.after");
        @(negedge clk); chk_out("seqC.after2", 0, 0, 0, 0, 0, 0); cycle_end("seqC.after2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end

endmodule
